nvram_upload: RTL and testbench

Serves the HPS read side of the ioctl upload path in the Cave core: when the HPS requests an NVRAM/EEPROM save, this block answers each `ioctl_rd` with a 16-bit word fetched from the on-chip NVRAM through a request/acknowledge port. It drives `ioctl_din` and `ioctl_wait` back to hps_io, stalling the HPS while a fetch is in flight. It also raises a lock flag so game-side NVRAM writes are held off for the duration of the upload.

---
 rtl/nvram_upload.sv | 209 ++++++++++++++++++++
 tb/tb_nvram_upload.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_upload.sv
// rtl/nvram_upload.sv - HPS ioctl read server for NVRAM upload, request/ack memory port
// Optional word prefetch behind `define NVRAM_UPLOAD_PREFETCH_EN.
module nvram_upload #(
  parameter int          ADDR_WIDTH   = 7,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd2
) (
  input  logic                  clk_sys,
  input  logic                  RESET,
  input  logic                  ioctl_upload,
  input  logic                  ioctl_rd,
  input  logic [7:0]            ioctl_index,
  input  logic [26:0]           ioctl_addr,
  output logic [15:0]           ioctl_din,
  output logic                  ioctl_wait,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_dout,
  output logic                  locked
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state;

  logic                  sess, rd_q, in_range;
  logic [ADDR_WIDTH-1:0] word;
  logic [15:0]           swapped;
  logic                  unused_lsb;

  assign sess       = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign rd_q       = ioctl_rd && sess;
  assign in_range   = (ioctl_addr[26:ADDR_WIDTH+1] == '0);
  assign word       = ioctl_addr[ADDR_WIDTH:1];
  assign swapped    = {mem_dout[7:0], mem_dout[15:8]};
  assign unused_lsb = ioctl_addr[0];

`ifdef NVRAM_UPLOAD_PREFETCH_EN
  logic                  pf_valid, pf_busy, refetch;
  logic [ADDR_WIDTH-1:0] pf_addr, pend_addr;
  logic [15:0]           pf_data;
  logic                  word_last, cur_last;
  logic [ADDR_WIDTH-1:0] word_nxt, cur_nxt;

  assign word_last = &word;
  assign cur_last  = &mem_addr;
  assign word_nxt  = word + 1'b1;
  assign cur_nxt   = mem_addr + 1'b1;

  // A prefetch is a background request in IDLE (pf_busy); a demand read that
  // collides with it either adopts it (same word) or drains it and refetches.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      ioctl_din  <= '0;
      ioctl_wait <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      locked     <= 1'b0;
      pf_valid   <= 1'b0;
      pf_busy    <= 1'b0;
      refetch    <= 1'b0;
      pf_addr    <= '0;
      pend_addr  <= '0;
      pf_data    <= '0;
    end else begin
      locked <= sess || (locked && (state != IDLE || mem_req));
      case (state)
        IDLE: begin
          if (pf_busy && !ioctl_upload) begin
            pf_busy <= 1'b0;
            if (mem_ack) mem_req <= 1'b0;
            else         state   <= DRAIN;
          end else if (rd_q && in_range) begin
            pf_valid <= 1'b0;
            if (pf_valid && word == pf_addr) begin
              ioctl_din <= pf_data;
              if (!word_last) begin
                mem_addr <= word_nxt;
                mem_req  <= 1'b1;
                pf_busy  <= 1'b1;
              end
            end else if (pf_busy) begin
              pf_busy <= 1'b0;
              if (word == mem_addr) begin
                if (mem_ack) begin
                  ioctl_din <= swapped;
                  if (!word_last) begin
                    mem_addr <= word_nxt;
                    pf_busy  <= 1'b1;
                  end else begin
                    mem_req <= 1'b0;
                  end
                end else begin
                  ioctl_wait <= 1'b1;
                  state      <= FETCH;
                end
              end else if (mem_ack) begin
                mem_addr   <= word;
                ioctl_wait <= 1'b1;
                state      <= FETCH;
              end else begin
                pend_addr  <= word;
                refetch    <= 1'b1;
                ioctl_wait <= 1'b1;
                state      <= DRAIN;
              end
            end else begin
              mem_addr   <= word;
              mem_req    <= 1'b1;
              ioctl_wait <= 1'b1;
              state      <= FETCH;
            end
          end else begin
            if (rd_q) ioctl_din <= 16'hFFFF;
            if (pf_busy && mem_ack) begin
              pf_data  <= swapped;
              pf_addr  <= mem_addr;
              pf_valid <= 1'b1;
              pf_busy  <= 1'b0;
              mem_req  <= 1'b0;
            end
          end
        end
        FETCH: begin
          if (mem_ack) begin
            ioctl_din  <= swapped;
            ioctl_wait <= 1'b0;
            state      <= IDLE;
            if (!cur_last && ioctl_upload) begin
              mem_addr <= cur_nxt;
              pf_busy  <= 1'b1;
            end else begin
              mem_req <= 1'b0;
            end
          end else if (!ioctl_upload) begin
            ioctl_wait <= 1'b0;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            refetch <= 1'b0;
            if (refetch && ioctl_upload) begin
              mem_addr <= pend_addr;
              state    <= FETCH;
            end else begin
              mem_req    <= 1'b0;
              ioctl_wait <= 1'b0;
              state      <= IDLE;
            end
          end else if (!ioctl_upload) begin
            refetch    <= 1'b0;
            ioctl_wait <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (!ioctl_upload) pf_valid <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      ioctl_din  <= '0;
      ioctl_wait <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      locked     <= 1'b0;
    end else begin
      // Hold the lock while any request is still outstanding to memory.
      locked <= sess || (locked && (state != IDLE || mem_req));
      case (state)
        IDLE: begin
          if (rd_q) begin
            if (!in_range) begin
              ioctl_din <= 16'hFFFF;
            end else begin
              mem_addr   <= word;
              mem_req    <= 1'b1;
              ioctl_wait <= 1'b1;
              state      <= FETCH;
            end
          end
        end
        FETCH: begin
          if (mem_ack) begin
            ioctl_din  <= swapped;
            mem_req    <= 1'b0;
            ioctl_wait <= 1'b0;
            state      <= IDLE;
          end else if (!ioctl_upload) begin
            ioctl_wait <= 1'b0;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_nvram_upload.sv
// tb/tb_nvram_upload.sv - scoreboard bench for nvram_upload with an auto-acking memory model
module tb_nvram_upload;

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic        ioctl_upload, ioctl_rd;
  logic [7:0]  ioctl_index;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_din;
  logic        ioctl_wait, mem_req, mem_ack, locked;
  logic [6:0]  mem_addr;
  logic [15:0] mem_dout;

  always #5 clk_sys = ~clk_sys;

  nvram_upload dut (
    .clk_sys(clk_sys), .RESET(RESET),
    .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_dout(mem_dout),
    .locked(locked)
  );

  logic [15:0] mem [128];
  logic [15:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat = 0;
  bit          auto_en = 1'b1;
  logic [6:0]  seen_addr;
  logic        seen_req;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sw(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  // Memory model: acks a held request after lat extra cycles.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk_sys);
      if (auto_en) begin
        mem_ack = 1'b0;
        if (mem_req) begin
          if (cnt >= lat) begin
            mem_ack  = 1'b1;
            mem_dout = mem[mem_addr];
            cnt      = 0;
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic do_read(input logic [26:0] a, output int waits);
    logic [15:0] e;
    logic [15:0] got;
    if (a[26:8] != 0) exp_q.push_back(16'hFFFF);
    else              exp_q.push_back(sw(mem[a[7:1]]));
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd  = 1'b0;
    seen_addr = mem_addr;
    seen_req  = mem_req;
    waits     = 0;
    while (ioctl_wait && waits < 100) begin
      waits++;
      @(negedge clk_sys);
    end
    if (waits >= 100) check("wait_timeout", waits, 0);
    got = ioctl_din;
    e   = exp_q.pop_front();
    check("rd_data", got, e);
  endtask

  initial begin
    int          w;
    logic [15:0] din_before;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          w;
    logic [15:0] din_before;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    mem[0]       = 16'h1234;
    RESET        = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ioctl_index  = 8'd2;
    ioctl_addr   = '0;
    mem_ack      = 1'b0;
    mem_dout     = '0;
    settle(3);
    check("rst_din", ioctl_din, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_locked", locked, 0);
    RESET = 1'b0;

    // Basic fetch with 3-cycle stall
    ioctl_upload = 1'b1;
    #1 check("locked_lag", locked, 0);
    @(negedge clk_sys);
    check("locked_up", locked, 1);
    lat = 2;
    do_read(27'h0, w);
    check("t1_waits", w, 3);
    check("t1_addr", seen_addr, 0);
    check("t1_wait_low", ioctl_wait, 0);

    // Range boundaries
    settle(6);
    lat = 0;
    do_read(27'h100, w);
    check("oor_waits", w, 0);
    check("oor_req", seen_req, 0);
    do_read(27'h4000000, w);
    check("oor_hi_waits", w, 0);
    do_read(27'hFE, w);
    check("last_waits", w, 1);
    check("last_addr", seen_addr, 127);

    // Unqualified strobes
    settle(6);
    ioctl_index = 8'd1;
    @(negedge clk_sys);
    din_before = ioctl_din;
    ioctl_addr = 27'h0;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check("idx_req", mem_req, 0);
    check("idx_wait", ioctl_wait, 0);
    check("idx_din", ioctl_din, din_before);
    check("idx_locked", locked, 0);
    ioctl_index  = 8'd2;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check("noup_req", mem_req, 0);
    check("noup_din", ioctl_din, din_before);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);

    // Random in-range reads, random ack latency and gaps
    for (int i = 0; i < 10; i++) begin
      lat = $urandom_range(0, 3);
      settle($urandom_range(0, 3));
      do_read({19'd0, 7'($urandom_range(0, 127)), 1'b0}, w);
    end

    // Sequential reads with ack latency 1
    settle(8);
    lat = 1;
    do_read(27'h0, w);
    check("seq0_waits", w, 2);
    settle(3);
    do_read(27'h2, w);
`ifdef NVRAM_UPLOAD_PREFETCH_EN
    check("seq2_waits", w, 0);
`else
    check("seq2_waits", w, 2);
`endif
    settle(3);
    do_read(27'h4, w);
`ifdef NVRAM_UPLOAD_PREFETCH_EN
    check("seq4_waits", w, 0);
`else
    check("seq4_waits", w, 2);
`endif

    // Upload drops while a fetch is outstanding
    settle(6);
    auto_en = 1'b0;
    mem_ack = 1'b0;
    din_before = ioctl_din;
    ioctl_addr = 27'd20;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check("drop_wait_hi", ioctl_wait, 1);
    check("drop_addr", mem_addr, 10);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("drop_wait_lo", ioctl_wait, 0);
    check("drop_req_held", mem_req, 1);
    check("drop_locked_held", locked, 1);
    @(negedge clk_sys);
    mem_ack  = 1'b1;
    mem_dout = 16'hBEEF;
    @(negedge clk_sys);
    mem_ack = 1'b0;
    check("drop_req_lo", mem_req, 0);
    check("drop_din", ioctl_din, din_before);
    @(negedge clk_sys);
    check("drop_locked_lo", locked, 0);

    // Reset mid-fetch, then a stray ack
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    ioctl_addr = 27'd6;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check("mid_req", mem_req, 1);
    RESET = 1'b1;
    #1;
    check("arst_din", ioctl_din, 0);
    check("arst_wait", ioctl_wait, 0);
    check("arst_req", mem_req, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_locked", locked, 0);
    @(negedge clk_sys);
    RESET        = 1'b0;
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    mem_ack  = 1'b1;
    mem_dout = 16'h5555;
    @(negedge clk_sys);
    mem_ack = 1'b0;
    check("stray_din", ioctl_din, 0);
    check("stray_req", mem_req, 0);
    check("stray_wait", ioctl_wait, 0);
    auto_en      = 1'b1;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    lat = 0;
    do_read(27'd8, w);
    check("recover_waits", w, 1);
    check("recover_addr", seen_addr, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
